// File: rtl/bcd_counter_scan7_pkg.sv
// Shared constants for BCD display blocks: digit width and active-high
// 7-segment patterns in {g,f,e,d,c,b,a} order.
package bcd_counter_scan7_pkg;

  localparam int BCD_W = 4;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/bcd_counter_scan7_dec.sv
// Combinational BCD digit to active-high 7-segment pattern.
// Non-BCD codes (10-15) decode to blank.
module bcd7seg_dec
  import bcd_counter_scan7_pkg::*;
(
  input  logic [BCD_W-1:0] i_bcd,
  output logic [6:0]       o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_counter_scan7.sv
// N-digit BCD up/down counter with load, wrap pulse and a time-multiplexed
// 7-segment driver with optional leading-zero blanking.
module bcd_counter_scan7
  import bcd_counter_scan7_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int SCAN_DIV       = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit BLANK_LZ       = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      up,
  input  logic                      load,
  input  logic [BCD_W*N_DIGITS-1:0] load_val,
  output logic [BCD_W*N_DIGITS-1:0] cnt,
  output logic                      carry,
  output logic [6:0]                seg,
  output logic [N_DIGITS-1:0]       an
);

  localparam int CNT_W = BCD_W * N_DIGITS;
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  localparam logic [6:0]          SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [N_DIGITS-1:0] AN_OFF  = {N_DIGITS{AN_ACTIVE_LOW}};

  logic [CNT_W-1:0]    r_cnt;
  logic                r_carry;
  logic [DIV_W-1:0]    r_div;
  logic [IDX_W-1:0]    r_idx;
  logic [6:0]          r_seg_p1;
  logic [N_DIGITS-1:0] r_an_p1;

  logic [CNT_W-1:0]    w_cnt_inc;
  logic [CNT_W-1:0]    w_cnt_dec;
  logic [CNT_W-1:0]    w_load_clean;
  logic                w_wrap_up;
  logic                w_wrap_dn;
  logic [N_DIGITS-1:0] w_zero_from;
  logic [BCD_W-1:0]    w_digit;
  logic [N_DIGITS-1:0] w_an;
  logic                w_blank;
  logic [6:0]          w_seg_dec;
  logic [6:0]          w_seg;

  // Ripple increment/decrement; a carry out of the top digit is a wrap.
  always_comb begin
    logic c_up;
    logic c_dn;
    w_cnt_inc    = r_cnt;
    w_cnt_dec    = r_cnt;
    w_load_clean = load_val;
    c_up         = 1'b1;
    c_dn         = 1'b1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (c_up) begin
        if (r_cnt[k*BCD_W +: BCD_W] == 4'd9) begin
          w_cnt_inc[k*BCD_W +: BCD_W] = '0;
        end else begin
          w_cnt_inc[k*BCD_W +: BCD_W] = r_cnt[k*BCD_W +: BCD_W] + 4'd1;
          c_up = 1'b0;
        end
      end
      if (c_dn) begin
        if (r_cnt[k*BCD_W +: BCD_W] == 4'd0) begin
          w_cnt_dec[k*BCD_W +: BCD_W] = 4'd9;
        end else begin
          w_cnt_dec[k*BCD_W +: BCD_W] = r_cnt[k*BCD_W +: BCD_W] - 4'd1;
          c_dn = 1'b0;
        end
      end
      if (load_val[k*BCD_W +: BCD_W] > 4'd9) begin
        w_load_clean[k*BCD_W +: BCD_W] = '0;
      end
    end
    w_wrap_up = c_up;
    w_wrap_dn = c_dn;
  end

  // w_zero_from[k]: digit k and every digit above it are zero.
  always_comb begin
    logic z;
    w_zero_from = '0;
    z           = 1'b1;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      z              = z && (r_cnt[k*BCD_W +: BCD_W] == 4'd0);
      w_zero_from[k] = z;
    end
  end

  always_comb begin
    w_digit = '0;
    w_an    = '0;
    w_blank = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (IDX_W'(k) == r_idx) begin
        w_digit = r_cnt[k*BCD_W +: BCD_W];
        w_an[k] = 1'b1;
        w_blank = BLANK_LZ && (k != 0) && w_zero_from[k];
      end
    end
  end

  bcd7seg_dec u_dec (
    .i_bcd (w_digit),
    .o_seg (w_seg_dec)
  );

  assign w_seg = w_blank ? SEG_BLANK : w_seg_dec;

  // Counter stage: reset > load > en > hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_carry <= 1'b0;
    end else if (load) begin
      r_cnt   <= w_load_clean;
      r_carry <= 1'b0;
    end else if (en) begin
      r_cnt   <= up ? w_cnt_inc : w_cnt_dec;
      r_carry <= up ? w_wrap_up : w_wrap_dn;
    end else begin
      r_carry <= 1'b0;
    end
  end

  // Scan stage: divider paces the digit index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div <= '0;
      r_idx <= '0;
    end else if (r_div == DIV_W'(SCAN_DIV - 1)) begin
      r_div <= '0;
      r_idx <= (r_idx == IDX_W'(N_DIGITS - 1)) ? '0 : r_idx + 1'b1;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Display output stage: polarity applied once, here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_seg_p1 <= SEG_OFF;
      r_an_p1  <= AN_OFF;
    end else begin
      r_seg_p1 <= SEG_ACTIVE_LOW ? ~w_seg : w_seg;
      r_an_p1  <= AN_ACTIVE_LOW ? ~w_an : w_an;
    end
  end

  assign cnt   = r_cnt;
  assign carry = r_carry;
  assign seg   = r_seg_p1;
  assign an    = r_an_p1;

endmodule
